// File: rtl/cfg_out_pea_writer.sv
// cfg_out_pea_writer: burst loader for the per-PE, per-port output-crossbar selector store.
// Build option: define CFG_OUT_PEA_READBACK_EN for a registered readback port;
// when it is undefined, rd_data_o is tied to 0.

package pea_pkg;
    localparam int N                = 4;
    localparam int KMEM_SIZE        = 8;
    localparam int N_ADDR_BITS_KMEM = 3;
endpackage

package xbar_pkg;
    localparam int M     = 6;
    localparam int LOG_M = 3;
endpackage

module cfg_out_pea_writer
    import pea_pkg::*;
    import xbar_pkg::*;
#(
    localparam int PE_W = (N > 1) ? $clog2(N) : 1,
    localparam int A    = N_ADDR_BITS_KMEM
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic                                           cmd_valid_i,
    output logic                                           cmd_ready_o,
    input  logic [A-1:0]                                   cmd_base_slot_i,
    input  logic [A:0]                                     cmd_num_slots_i,
    input  logic                                           data_valid_i,
    output logic                                           data_ready_o,
    input  logic [LOG_M-1:0]                               data_i,
    input  logic                                           abort_i,
    output logic                                           busy_o,
    output logic                                           done_o,
    output logic                                           err_o,
    input  logic [PE_W-1:0]                                rd_pe_i,
    input  logic                                           rd_port_i,
    input  logic [A-1:0]                                   rd_slot_i,
    output logic [LOG_M-1:0]                               rd_data_o,
    output logic [N-1:0][1:0][KMEM_SIZE-1:0][LOG_M-1:0]    reg_cfg_sel_out_pea_o
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
    typedef logic [N-1:0][1:0][KMEM_SIZE-1:0][LOG_M-1:0] store_t;

    state_e          state_q, state_d;
    logic [A-1:0]    base_q, base_d;
    logic [A:0]      count_q, count_d;
    logic [A:0]      slot_cnt_q, slot_cnt_d;
    logic [PE_W-1:0] pe_q, pe_d;
    logic            port_q, port_d;
    logic            err_q, err_d;
    store_t          store_q, store_d;
    logic [A+1:0]    slot_sum;
    logic [A-1:0]    slot;
    logic            beat, last_pe, last_beat;

    // Ready/status outputs come only from the state register, so no valid-to-ready path exists.
    assign cmd_ready_o           = state_q == IDLE;
    assign data_ready_o          = state_q == LOAD;
    assign busy_o                = state_q == LOAD;
    assign done_o                = state_q == DONE;
    assign err_o                 = err_q;
    assign reg_cfg_sel_out_pea_o = store_q;

    assign beat      = (state_q == LOAD) && data_valid_i;
    assign slot_sum  = (A+2)'(base_q) + (A+2)'(slot_cnt_q);
    assign slot      = A'(slot_sum % (A+2)'(KMEM_SIZE));
    assign last_pe   = pe_q == PE_W'(N - 1);
    assign last_beat = port_q && last_pe && (slot_cnt_q == count_q - (A+1)'(1));

    // Next-state logic: command latch, beat walk (port, then PE, then slot), store writes.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        slot_cnt_d = slot_cnt_q;
        pe_d       = pe_q;
        port_d     = port_q;
        err_d      = err_q;
        store_d    = store_q;
        unique case (state_q)
            IDLE: if (cmd_valid_i) begin
                base_d     = cmd_base_slot_i;
                count_d    = cmd_num_slots_i;
                err_d      = 1'b0;
                slot_cnt_d = '0;
                pe_d       = '0;
                port_d     = 1'b0;
                state_d    = (cmd_num_slots_i == '0) ? DONE : LOAD;
            end
            LOAD: begin
                if (beat) begin
                    store_d[pe_q][port_q][slot] = data_i;
                    err_d  = err_q || (int'(data_i) >= M);
                    port_d = ~port_q;
                    pe_d   = port_q ? (last_pe ? '0 : pe_q + PE_W'(1)) : pe_q;
                    slot_cnt_d = (port_q && last_pe) ? slot_cnt_q + (A+1)'(1) : slot_cnt_q;
                end
                state_d = (abort_i || (beat && last_beat)) ? DONE : LOAD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and store registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            slot_cnt_q <= '0;
            pe_q       <= '0;
            port_q     <= 1'b0;
            err_q      <= 1'b0;
            store_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            slot_cnt_q <= slot_cnt_d;
            pe_q       <= pe_d;
            port_q     <= port_d;
            err_q      <= err_d;
            store_q    <= store_d;
        end
    end

`ifdef CFG_OUT_PEA_READBACK_EN
    logic [LOG_M-1:0] rd_q, rd_d;

    // Readback lookup into the store as of the previous edge.
    always_comb rd_d = store_q[rd_pe_i][rd_port_i][rd_slot_i];

    // One-cycle registered readback.
    always_ff @(posedge clk_i) begin
        if (rst_i) rd_q <= '0;
        else       rd_q <= rd_d;
    end

    assign rd_data_o = rd_q;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_pe_i, rd_port_i, rd_slot_i};
    assign rd_data_o = '0;
`endif
endmodule

// File: tb/tb_cfg_out_pea_writer.sv
// tb_cfg_out_pea_writer: directed bench for the selector-store burst writer.
module tb_cfg_out_pea_writer;
    import pea_pkg::*;
    import xbar_pkg::*;

    typedef logic [N-1:0][1:0][KMEM_SIZE-1:0][LOG_M-1:0] store_t;

    logic                          clk = 1'b0;
    logic                          rst_i = 1'b1;
    logic                          cmd_valid_i = 1'b0;
    logic                          cmd_ready_o;
    logic [N_ADDR_BITS_KMEM-1:0]   cmd_base_slot_i = '0;
    logic [N_ADDR_BITS_KMEM:0]     cmd_num_slots_i = '0;
    logic                          data_valid_i = 1'b0;
    logic                          data_ready_o;
    logic [LOG_M-1:0]              data_i = '0;
    logic                          abort_i = 1'b0;
    logic                          busy_o, done_o, err_o;
    logic [1:0]                    rd_pe_i = '0;
    logic                          rd_port_i = 1'b0;
    logic [N_ADDR_BITS_KMEM-1:0]   rd_slot_i = '0;
    logic [LOG_M-1:0]              rd_data_o;
    store_t                        store;
    store_t                        exp_st;
    int                            checks = 0;
    int                            errors = 0;
    int                            done_cnt = 0;

    cfg_out_pea_writer dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_base_slot_i(cmd_base_slot_i), .cmd_num_slots_i(cmd_num_slots_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rd_pe_i(rd_pe_i), .rd_port_i(rd_port_i), .rd_slot_i(rd_slot_i),
        .rd_data_o(rd_data_o), .reg_cfg_sel_out_pea_o(store)
    );

    always #5 clk = ~clk;

    // Count done pulses as seen at the sampling edge.
    always @(negedge clk) if (done_o === 1'b1) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic cmd(input int b, input int n);
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i     = 1'b1;
        cmd_base_slot_i = 3'(b);
        cmd_num_slots_i = 4'(n);
        cyc();
        cmd_valid_i     = 1'b0;
    endtask

    task automatic beat(input int d, input logic ab);
        chk("data_ready_load", data_ready_o, 1);
        data_valid_i = 1'b1;
        data_i       = 3'(d);
        abort_i      = ab;
        cyc();
        data_valid_i = 1'b0;
        abort_i      = 1'b0;
    endtask

    initial begin
        exp_st = '0;
        cyc();
        cyc();
        rst_i = 1'b0;
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_data_ready", data_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rd", rd_data_o, 0);
        chk("rst_store", store, 0);
        // Basic burst: base 2, one slot.
        cmd(2, 1);
        chk("b_busy", busy_o, 1);
        chk("b_cmd_ready", cmd_ready_o, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++) begin
                beat((2 * i + j) % 6, 1'b0);
                exp_st[i][j][2] = 3'((2 * i + j) % 6);
            end
        chk("b_done", done_o, 1);
        chk("b_done_busy", busy_o, 0);
        chk("b_done_dready", data_ready_o, 0);
        chk("b_done_cready", cmd_ready_o, 0);
        cyc();
        chk("b_done_low", done_o, 0);
        chk("b_store", store, exp_st);
        chk("b_done_cnt", done_cnt, 1);
        // Wrap-around: base 7, two slots, all fives.
        cmd(7, 2);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 2; j++) begin
                    beat(5, 1'b0);
                    exp_st[i][j][(7 + k) % 8] = 3'd5;
                end
        chk("w_done", done_o, 1);
        cyc();
        chk("w_store", store, exp_st);
        chk("w_done_cnt", done_cnt, 2);
        chk("w_err", err_o, 0);
        // Backpressure with one out-of-range beat.
        cmd(1, 1);
        begin
            int n = 0;
            for (int k = 0; k < 15; k++) begin
                if (k == 6) chk("bp_err_before", err_o, 0);
                if (k == 7) chk("bp_err_after", err_o, 1);
                if (k % 2 == 0) begin
                    chk("bp_dready", data_ready_o, 1);
                    data_valid_i = 1'b1;
                    data_i = (n == 3) ? 3'd7 : 3'd1;
                    exp_st[n / 2][n % 2][1] = data_i;
                    n++;
                end else data_valid_i = 1'b0;
                cyc();
            end
        end
        data_valid_i = 1'b0;
        chk("bp_done", done_o, 1);
        chk("bp_err_hold", err_o, 1);
        cyc();
        chk("bp_store", store, exp_st);
        chk("bp_done_cnt", done_cnt, 3);
        chk("bp_err_sticky", err_o, 1);
        // Zero-count command clears err and finishes at once.
        cmd(3, 0);
        chk("z_done", done_o, 1);
        chk("z_err_clr", err_o, 0);
        chk("z_busy", busy_o, 0);
        cyc();
        chk("z_store", store, exp_st);
        chk("z_done_cnt", done_cnt, 4);
        // Abort on the third beat; that beat is still written.
        cmd(4, 2);
        beat(3, 1'b0);
        beat(2, 1'b0);
        beat(1, 1'b1);
        exp_st[0][0][4] = 3'd3;
        exp_st[0][1][4] = 3'd2;
        exp_st[1][0][4] = 3'd1;
        chk("a_done", done_o, 1);
        cyc();
        chk("a_store", store, exp_st);
        chk("a_done_cnt", done_cnt, 5);
        chk("a_cmd_ready", cmd_ready_o, 1);
        // Reset mid-burst after five beats.
        cmd(5, 1);
        for (int n = 0; n < 5; n++) beat(7, 1'b0);
        chk("r_err_pre", err_o, 1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        exp_st = '0;
        chk("r_cmd_ready", cmd_ready_o, 1);
        chk("r_busy", busy_o, 0);
        chk("r_done", done_o, 0);
        chk("r_err", err_o, 0);
        chk("r_rd", rd_data_o, 0);
        chk("r_store", store, exp_st);
        cyc();
        chk("r_done_cnt", done_cnt, 5);
        // Write 4 to store[3][1][5], then read it back.
        cmd(5, 1);
        for (int n = 0; n < 8; n++) begin
            beat((n == 7) ? 4 : 2, 1'b0);
            exp_st[n / 2][n % 2][5] = (n == 7) ? 3'd4 : 3'd2;
        end
        chk("rb_done", done_o, 1);
        rd_pe_i = 2'd3;
        rd_port_i = 1'b1;
        rd_slot_i = 3'd5;
        cyc();
`ifdef CFG_OUT_PEA_READBACK_EN
        chk("rb_315", rd_data_o, 4);
`else
        chk("rb_315_off", rd_data_o, 0);
`endif
        rd_pe_i = 2'd0;
        rd_port_i = 1'b0;
        cyc();
`ifdef CFG_OUT_PEA_READBACK_EN
        chk("rb_005", rd_data_o, 2);
`else
        chk("rb_005_off", rd_data_o, 0);
`endif
        chk("rb_store", store, exp_st);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
